// File: rtl/vpulse_pkg.sv
// Shared types and edge-shape constants for the pulse scheduler.
package vpulse_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RISE = 3'd1,
    HIGH = 3'd2,
    FALL = 3'd3,
    LOW  = 3'd4,
    DONE = 3'd5
  } vps_state_t;

  // Intermediate edge levels as fractions of the latched amplitude.
  localparam real EDGE_FRAC [0:3] = '{1.0 / 30.0, 0.5, 29.0 / 30.0, 1.0};

  function automatic real edge_level(input real a, input int idx);
    return a * EDGE_FRAC[idx & 3];
  endfunction

endpackage

// File: rtl/vpulse_edge_gen.sv
// Walks the three intermediate edge levels, holding each for EDGE_CYC cycles.
// dir = 1 walks L0->L1->L2 (rise), dir = 0 walks L2->L1->L0 (fall).
// edge_done is high on the last cycle of the walk so the FSM can leave the
// edge state on that same clock edge.
module vpulse_edge_gen
  import vpulse_pkg::*;
#(
  parameter int EDGE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dir,
  input  logic go,
  input  real  amp,
  output real  level,
  output logic edge_done
);

  localparam logic [3:0] HOLD_LD = 4'(EDGE_CYC - 1);

  logic [1:0] step;
  logic [3:0] hold;
  logic [1:0] lvl_idx;

  // Hold down-counter and step index; both rearm whenever go is low so the
  // walk always starts at the first level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= 2'd0;
      hold <= 4'd0;
    end else if (!go) begin
      step <= 2'd0;
      hold <= HOLD_LD;
    end else if (hold == 4'd0) begin
      hold <= HOLD_LD;
      step <= (step == 2'd2) ? 2'd0 : step + 2'd1;
    end else begin
      hold <= hold - 4'd1;
    end
  end

  // Level selection and terminal-count detect.
  always_comb begin
    lvl_idx   = dir ? step : (2'd2 - step);
    level     = edge_level(amp, int'(lvl_idx));
    edge_done = go && (step == 2'd2) && (hold == 4'd0);
  end

endmodule

// File: rtl/vpulse_sched.sv
// Cycle-exact shaped pulse-burst scheduler driving a real-valued level.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; vout = 0.0
// RISE  | edge generator walks L0..L2 upward
// HIGH  | plateau at the latched amplitude for W cycles
// FALL  | edge generator walks L2..L0 downward
// LOW   | zero plateau for P - W - 2E cycles (skipped when zero)
// DONE  | single-cycle done pulse, then IDLE
module vpulse_sched
  import vpulse_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int EDGE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  real              cfg_amp,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output real              vout,
  output logic [CNT_W-1:0] pulse_idx
);

  // One extra bit so width + 2E cannot overflow.
  localparam int CW = CNT_W + 1;
  localparam logic [CW-1:0] EDGE2 = CW'(6 * EDGE_CYC);

  vps_state_t       state, state_nxt;
  real              amp_q;
  logic [CNT_W-1:0] width_q, period_q, count_q;
  logic [CW-1:0]    timer;
  logic             stop_pend;

  logic [CW-1:0] need_len;
  logic [CW-1:0] low_len;
  logic          cfg_ok;
  logic          last_pulse;
  logic          accept, reject, load_hi, load_lo, pulse_end;
  logic          eg_go, eg_dir, edge_done;
  real           eg_level;

  assign need_len   = {1'b0, cfg_width} + EDGE2;
  assign cfg_ok     = (cfg_width != '0) && ({1'b0, cfg_period} >= need_len);
  assign low_len    = {1'b0, period_q} - {1'b0, width_q} - EDGE2;
  // A stop seen on the closing cycle of a pulse still ends the burst there.
  assign last_pulse = stop_pend || stop ||
                      ((count_q != '0) && ((pulse_idx + CNT_W'(1)) == count_q));

  assign eg_go  = (state == RISE) || (state == FALL);
  assign eg_dir = (state == RISE);

  vpulse_edge_gen #(
    .EDGE_CYC (EDGE_CYC)
  ) u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .dir       (eg_dir),
    .go        (eg_go),
    .amp       (amp_q),
    .level     (eg_level),
    .edge_done (edge_done)
  );

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    load_hi   = 1'b0;
    load_lo   = 1'b0;
    pulse_end = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept    = 1'b1;
            state_nxt = RISE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RISE: begin
        if (edge_done) begin
          load_hi   = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (timer == '0) state_nxt = FALL;
      end
      FALL: begin
        if (edge_done) begin
          if (low_len == '0) begin
            pulse_end = 1'b1;
            state_nxt = last_pulse ? DONE : RISE;
          end else begin
            load_lo   = 1'b1;
            state_nxt = LOW;
          end
        end
      end
      LOW: begin
        if (timer == '0) begin
          pulse_end = 1'b1;
          state_nxt = last_pulse ? DONE : RISE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, latched configuration, plateau timer and burst bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      amp_q     <= 0.0;
      width_q   <= '0;
      period_q  <= '0;
      count_q   <= '0;
      timer     <= '0;
      stop_pend <= 1'b0;
      pulse_idx <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= reject;
      if (accept) begin
        amp_q     <= cfg_amp;
        width_q   <= cfg_width;
        period_q  <= cfg_period;
        count_q   <= cfg_count;
        pulse_idx <= '0;
      end else if (pulse_end) begin
        pulse_idx <= pulse_idx + CNT_W'(1);
      end
      if (load_hi) begin
        timer <= {1'b0, width_q} - CW'(1);
      end else if (load_lo) begin
        timer <= low_len - CW'(1);
      end else if (((state == HIGH) || (state == LOW)) && (timer != '0)) begin
        timer <= timer - CW'(1);
      end
      if (accept || (state_nxt == DONE)) begin
        stop_pend <= 1'b0;
      end else if (stop && busy) begin
        stop_pend <= 1'b1;
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy = (state == RISE) || (state == HIGH) || (state == FALL) || (state == LOW);
    done = (state == DONE);
    case (state)
      RISE, FALL: vout = eg_level;
      HIGH:       vout = amp_q;
      default:    vout = 0.0;
    endcase
  end

endmodule

// File: tb/tb_vpulse_sched.sv
// Self-checking bench for vpulse_sched: directed test-plan bursts plus
// randomized bursts checked against a per-cycle waveform model.
module tb_vpulse_sched;

  localparam int CNT_W = 16;
  localparam int EC    = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  real              cfg_amp = 0.0;
  logic [CNT_W-1:0] cfg_width = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             busy, done, cfg_err;
  real              vout;
  logic [CNT_W-1:0] pulse_idx;

  int checks = 0;
  int errors = 0;

  vpulse_sched #(
    .CNT_W    (CNT_W),
    .EDGE_CYC (EC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_amp    (cfg_amp),
    .cfg_width  (cfg_width),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .vout       (vout),
    .pulse_idx  (pulse_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input real obs, input real exp);
    checks++;
    assert (((obs - exp) < 1e-9) && ((exp - obs) < 1e-9)) else begin
      errors++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  function automatic real frac_lvl(input real a, input int k);
    if (k == 0) return a / 30.0;
    if (k == 1) return a / 2.0;
    return 29.0 * a / 30.0;
  endfunction

  // Runs one burst. stop_k >= 0 raises stop in the first plateau cycle of
  // pulse stop_k. with_stop raises stop together with start. A second start
  // is always raised inside the burst and must be ignored.
  task automatic run_burst(input real a, input int w, input int p, input int n,
                           input int stop_k, input bit with_stop);
    real exp_v[$];
    int  np;
    int  stop_cyc;
    np = n;
    if (stop_k >= 0 && (n == 0 || stop_k < n)) np = stop_k + 1;
    stop_cyc = (stop_k >= 0) ? stop_k * p + 3 * EC : -1;
    for (int k = 0; k < np; k++) begin
      for (int l = 0; l < 3; l++) repeat (EC) exp_v.push_back(frac_lvl(a, l));
      repeat (w) exp_v.push_back(a);
      for (int l = 2; l >= 0; l--) repeat (EC) exp_v.push_back(frac_lvl(a, l));
      repeat (p - w - 6 * EC) exp_v.push_back(0.0);
    end

    @(posedge clk); #1;
    cfg_amp    = a;
    cfg_width  = CNT_W'(w);
    cfg_period = CNT_W'(p);
    cfg_count  = CNT_W'(n);
    start      = 1'b1;
    stop       = with_stop;
    @(posedge clk); #1;
    start      = 1'b0;
    stop       = 1'b0;
    // Mid-burst config churn must not affect the running burst.
    cfg_amp    = 9.9;
    cfg_width  = CNT_W'($urandom_range(1, 3));
    cfg_period = CNT_W'($urandom_range(10, 30));
    cfg_count  = CNT_W'($urandom_range(0, 3));

    for (int i = 0; i < exp_v.size(); i++) begin
      @(negedge clk);
      chk_r("vout", vout, exp_v[i]);
      chk("busy", 32'(busy), 32'd1);
      chk("done_low", 32'(done), 32'd0);
      chk("cfg_err_busy", 32'(cfg_err), 32'd0);
      chk("pulse_idx", 32'(pulse_idx), 32'(i / p));
      stop  = (i == stop_cyc);
      start = (i == 1);
    end
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk_r("vout_done", vout, 0.0);
    chk("idx_final", 32'(pulse_idx), 32'(np));
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
    chk("idx_hold", 32'(pulse_idx), 32'(np));
    chk_r("vout_idle", vout, 0.0);
  endtask

  task automatic try_reject(input int w, input int p);
    @(posedge clk); #1;
    cfg_amp    = 1.0;
    cfg_width  = CNT_W'(w);
    cfg_period = CNT_W'(p);
    cfg_count  = CNT_W'(1);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("cfg_err", 32'(cfg_err), 32'd1);
    chk("rej_busy", 32'(busy), 32'd0);
    chk_r("rej_vout", vout, 0.0);
    @(negedge clk);
    chk("cfg_err_once", 32'(cfg_err), 32'd0);
    chk("rej_busy2", 32'(busy), 32'd0);
  endtask

  initial begin
    // Power-on reset values.
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_idx", 32'(pulse_idx), 32'd0);
    chk_r("rst_vout", vout, 0.0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-rise at L1 drops everything immediately.
    @(posedge clk); #1;
    cfg_amp = 2.0; cfg_width = 16'd3; cfg_period = 16'd12; cfg_count = 16'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    chk_r("pre_rst_L1", vout, 1.0);
    rst_n = 1'b0;
    #1;
    chk_r("arst_vout", vout, 0.0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_idx", 32'(pulse_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pulse waveform, done timing.
    run_burst(3.0, 4, 12, 1, -1, 1'b0);
    // Continuous mode stopped mid-plateau of pulse index 2.
    run_burst(1.0, 2, 8, 0, 2, 1'b0);
    // No low plateau between pulses.
    run_burst(1.5, 2, 8, 2, -1, 1'b0);
    // Start and stop together in IDLE: stop ignored, both pulses run.
    run_burst(2.0, 3, 10, 2, -1, 1'b1);
    // Rejected starts.
    try_reject(5, 10);
    try_reject(0, 20);
    // Exactly at the minimum period is accepted.
    run_burst(0.8, 5, 11, 1, -1, 1'b0);

    // Randomized bursts.
    for (int t = 0; t < 8; t++) begin
      int  w, p, n, sk;
      real a;
      w  = $urandom_range(1, 6);
      p  = w + 6 * EC + $urandom_range(0, 4);
      n  = $urandom_range(0, 3);
      sk = (n == 0) ? $urandom_range(0, 2) : ($urandom_range(0, 1) == 1 ? $urandom_range(0, n) : -1);
      a  = 0.5 + real'($urandom_range(0, 40)) / 10.0;
      run_burst(a, w, p, n, sk, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vpulse_sched.md
Name: vpulse_sched

Overview:
- Clocked scheduler that sequences a shaped pulse train onto a real-valued voltage level.
- Its real output drives an ideal voltage-source wrapper, which places the value on an EEnet node with zero drive resistance.
- Replaces free-running, delay-based pulse generation with cycle-exact, software-configured bursts.
- Used by CDR testbenches and DMS stimulus to inject timed bursts with start/done handshaking.

Parameters:
- CNT_W, 16, width of the width/period/count configuration fields.
- EDGE_CYC, 1, clock cycles held at each intermediate edge level; legal range 1..15.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- cfg_amp, input, real, pulse amplitude in volts; sampled at start.
- cfg_width, input, CNT_W, high-plateau length in cycles; sampled at start.
- cfg_period, input, CNT_W, full pulse period in cycles; sampled at start.
- cfg_count, input, CNT_W, pulses per burst; 0 means continuous until stop.
- start, input, 1, one-cycle request to begin a burst.
- stop, input, 1, one-cycle request to end the burst gracefully.
- busy, output, 1, high while a burst is active.
- done, output, 1, one-cycle pulse when a burst completes or is aborted.
- cfg_err, output, 1, one-cycle pulse when a start is rejected.
- vout, output, real, shaped level for the voltage-source wrapper.
- pulse_idx, output, CNT_W, index of the current pulse, 0-based.

Behaviour:
- Reset (async assert, sync release) forces every output and internal register:
  - state IDLE;
  - vout = 0.0;
  - busy = 0, done = 0, cfg_err = 0;
  - pulse_idx = 0;
  - all counters 0.
- Edge levels are fractions of the latched amplitude A, L[0..3] = {A/30, A/2, 29A/30, A}.
  - Rise walks L0→L1→L2, holding each level EDGE_CYC cycles, then enters HIGH at L3.
  - Fall walks L2→L1→L0, holding each level EDGE_CYC cycles, then enters LOW at 0.0.
- One edge lasts E = 3*EDGE_CYC cycles.
- Start validation, checked only in IDLE:
  - rejected when cfg_width == 0 or cfg_period < cfg_width + 2E;
  - a rejected start pulses cfg_err for one cycle and the block stays in IDLE.
- On a valid start: latch A, W, P, N and enter RISE on the next cycle.
  - busy rises in that same cycle.
- States and transitions:
  - IDLE: vout = 0.0. A valid start goes to RISE.
  - RISE: after E cycles, go to HIGH.
  - HIGH: vout = A; after W cycles, go to FALL.
  - FALL: after E cycles, go to LOW.
  - LOW: vout = 0.0; held P − W − 2E cycles, which may be 0, in which case LOW is skipped.
    - At the end of LOW, pulse_idx increments.
    - If the count is reached (N != 0 and pulse_idx+1 == N), or a stop is pending, go to DONE.
    - Otherwise go to RISE.
  - DONE: exactly one cycle; done = 1, busy = 0, vout = 0.0, then IDLE.
- Total cycles from start to done for N pulses: 1 + N*P + 1.
  - Example: P = 10, N = 2 gives done asserted in cycle 22 after start.
- stop:
  - Sets a sticky stop_pend flag. The pulse in flight always completes; there is no truncated edge.
  - stop in IDLE is ignored.
  - stop_pend clears on entry to DONE.
- start while busy is ignored, with no cfg_err.
- start and stop in the same cycle while IDLE: start wins and stop is ignored.
- cfg_* changes mid-burst have no effect until the next start.
- pulse_idx:
  - Wraps modulo 2^CNT_W in continuous mode.
  - Resets to 0 on a valid start.
  - Holds its final value after DONE.
- Counters are CNT_W+1 bits wide so the 2E sum cannot overflow; the comparison is unsigned.
- An asynchronous reset mid-pulse drops vout to 0.0 immediately, with no shaped fall.

Decomposition:
- Shared package vpulse_pkg holds:
  - state enum vps_state_t {IDLE, RISE, HIGH, FALL, LOW, DONE};
  - edge fraction constants EDGE_FRAC[4] = {1/30, 1/2, 29/30, 1.0};
  - function edge_level(real a, int idx).
- One natural sub-module, vpulse_edge_gen: walks the 4-level ramp.
  - Inputs: dir, go, A.
  - Outputs: level, edge_done.
  - Contains the EDGE_CYC hold counter.
- The top level holds the FSM, burst/period counters, and validation.

Test Plan:
- Reset in RISE at level L1 (A = 2.0) → vout = 0.0 during reset; busy/done = 0; pulse_idx = 0.
- A = 3.0, W = 4, P = 12, N = 1, EDGE_CYC = 1:
  - vout sequence from the cycle after start: 0.1, 1.5, 2.9, 3.0×4, 2.9, 1.5, 0.1, 0.0×2;
  - done in cycle 14 after start.
- A = 1.0, W = 2, P = 8, N = 0 (continuous); stop asserted mid-HIGH of pulse 3 (idx 2):
  - pulse 3 completes fully;
  - done follows that pulse's LOW;
  - pulse_idx = 3.
- Start with W = 5, P = 10, EDGE_CYC = 1 (needs 11):
  - cfg_err pulses one cycle;
  - busy stays 0 and vout stays 0.0.
- Boundary case P = W + 2E, e.g. W = 2, P = 8, EDGE_CYC = 1, N = 2:
  - no LOW plateau; the fall's final L0 goes directly to the next rise's L0;
  - done at cycle 18.
- Start while busy, and start+stop together in IDLE:
  - the first start is ignored with no cfg_err;
  - start+stop in IDLE starts a burst with stop_pend clear.
